// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant: single requester wins outright, ties go
// round-robin against last_grant or to port 1 when fixed_prio is set.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       grant_idx,
  output logic       grant_valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    grant_valid = |req;
    grant_idx   = PORT_IF;
    case (req)
      2'b01:   grant_idx = PORT_IF;
      2'b10:   grant_idx = PORT_LS;
      2'b11:   grant_idx = fixed_prio ? PORT_LS : ~last_grant;
      default: grant_idx = PORT_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch (port 0) and load/store (port 1) accesses onto
// one Memory, with address range checking and a one-cycle ack per access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_we;
  logic              cmd_err;
  logic              cmd_port;
  logic              last_grant;

  logic              grant_idx;
  logic              grant_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic [DATA_W-1:0] resp_rdata;

  rr_arb2 u_rr_arb2 (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  assign sel_addr  = (grant_idx == PORT_LS) ? p1_addr  : p0_addr;
  assign sel_wdata = (grant_idx == PORT_LS) ? p1_wdata : p0_wdata;
  assign sel_we    = (grant_idx == PORT_LS) ? p1_we    : p0_we;

  // Writes and rejected accesses return zero rather than whatever Memory presents.
  assign resp_rdata = (cmd_we || cmd_err) ? '0 : mem_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_valid) state_d = ST_BUSY;
      ST_BUSY: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_we     <= 1'b0;
      cmd_err    <= 1'b0;
      cmd_port   <= PORT_IF;
      last_grant <= PORT_LS;
      p0_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_ack     <= 1'b0;
      p1_err     <= 1'b0;
      p1_rdata   <= '0;
    end else begin
      state_q <= state_d;
      p0_ack  <= 1'b0;
      p1_ack  <= 1'b0;
      if (state_q == ST_IDLE && grant_valid) begin
        cmd_addr   <= sel_addr;
        cmd_wdata  <= sel_wdata;
        cmd_we     <= sel_we;
        cmd_err    <= (sel_addr >= ADDR_W'(MEM_WORDS));
        cmd_port   <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state_q == ST_BUSY) begin
        if (cmd_port == PORT_LS) begin
          p1_ack   <= 1'b1;
          p1_err   <= cmd_err;
          p1_rdata <= resp_rdata;
        end else begin
          p0_ack   <= 1'b1;
          p0_err   <= cmd_err;
          p0_rdata <= resp_rdata;
        end
      end
    end
  end

  // rst_n gates the strobe directly so a reset landing in BUSY cannot commit a write.
  assign mem_wen   = (state_q == ST_BUSY) & cmd_we & ~cmd_err & rst_n;
  assign mem_raddr = cmd_addr;
  assign mem_waddr = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a behavioural
// negedge memory, plus a fixed-priority instance for the tie-break case.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_wen, busy;

  logic        f_p0_req, f_p1_req;
  logic        f_p0_ack, f_p0_err, f_p1_ack, f_p1_err;
  logic [31:0] f_p0_rdata, f_p1_rdata;
  logic [31:0] f_mem_raddr, f_mem_waddr, f_mem_wdata, f_mem_rdata;
  logic        f_mem_wen, f_busy;

  logic [31:0] mem [0:1023];
  int          wen_count;
  logic [31:0] last_waddr;
  int          n_cmp;
  int          n_fail;
  int          wen_base;

  mem_arbiter #(.MEM_WORDS(1024), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_WORDS(1024), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(f_p0_req), .p0_we(1'b0), .p0_addr(32'd8), .p0_wdata(32'd0),
    .p0_ack(f_p0_ack), .p0_err(f_p0_err), .p0_rdata(f_p0_rdata),
    .p1_req(f_p1_req), .p1_we(1'b0), .p1_addr(32'd9), .p1_wdata(32'd0),
    .p1_ack(f_p1_ack), .p1_err(f_p1_err), .p1_rdata(f_p1_rdata),
    .mem_raddr(f_mem_raddr), .mem_waddr(f_mem_waddr), .mem_wdata(f_mem_wdata),
    .mem_wen(f_mem_wen), .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: reads and writes happen on negedge; out-of-range writes are dropped.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5]    = 32'hDEAD_BEEF;
    mem[3]    = 32'h0000_3333;
    mem[1023] = 32'h5A5A_0001;
    wen_count   = 0;
    last_waddr  = 32'h0;
    mem_rdata   = 32'h0;
    f_mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_wen) begin
        wen_count++;
        last_waddr = mem_waddr;
        if (mem_waddr < 32'd1024) mem[mem_waddr[9:0]] = mem_wdata;
      end
      mem_rdata   = (mem_raddr < 32'd1024) ? mem[mem_raddr[9:0]] : 32'h0;
      f_mem_rdata = {16'hC0DE, f_mem_raddr[15:0]};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;
    f_p0_req = 1'b0; f_p1_req = 1'b0;

    // Reset held three cycles with both requests asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p0_ack", 32'(p0_ack), 32'd0);
      check("rst_p1_ack", 32'(p1_ack), 32'd0);
      check("rst_wen", 32'(mem_wen), 32'd0);
    end
    check("rst_p0_rdata", p0_rdata, 32'h0);
    check("rst_p1_rdata", p1_rdata, 32'h0);
    rst_n = 1'b1;
    #2;
    check("rel_no_grant_yet", 32'(busy), 32'd0);
    step();
    check("rel_busy", 32'(busy), 32'd1);
    step();
    check("first_tie_p0", 32'(p0_ack), 32'd1);
    check("first_tie_p1", 32'(p1_ack), 32'd0);
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Single read of preloaded word
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5;
    step();
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_early_ack", 32'(p0_ack), 32'd0);
    step();
    check("rd_ack", 32'(p0_ack), 32'd1);
    check("rd_data", p0_rdata, 32'hDEAD_BEEF);
    check("rd_err", 32'(p0_err), 32'd0);
    check("rd_p1_ack", 32'(p1_ack), 32'd0);
    check("rd_idle", 32'(busy), 32'd0);
    p0_req = 1'b0;
    step();
    check("rd_ack_drop", 32'(p0_ack), 32'd0);
    check("rd_hold", p0_rdata, 32'hDEAD_BEEF);

    // Write then read back on port 1
    wen_base = wen_count;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd7; p1_wdata = 32'h0000_1234;
    step();
    check("wr_wen", 32'(mem_wen), 32'd1);
    check("wr_waddr", mem_waddr, 32'd7);
    check("wr_wdata", mem_wdata, 32'h0000_1234);
    step();
    check("wr_ack", 32'(p1_ack), 32'd1);
    check("wr_rdata", p1_rdata, 32'h0);
    check("wr_err", 32'(p1_err), 32'd0);
    p1_we = 1'b0;
    step();
    check("rb_busy", 32'(busy), 32'd1);
    step();
    check("rb_ack", 32'(p1_ack), 32'd1);
    check("rb_data", p1_rdata, 32'h0000_1234);
    check("wr_wen_once", 32'(wen_count - wen_base), 32'd1);
    check("wr_last_waddr", last_waddr, 32'd7);
    p1_req = 1'b0;
    step();

    // Round-robin contention; last grant was port 1, so port 0 goes first
    p0_req = 1'b1; p0_addr = 32'd5;
    p1_req = 1'b1; p1_addr = 32'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_busy", 32'(busy), 32'd1);
      check("rr_quiet", 32'({p1_ack, p0_ack}), 32'd0);
      step();
      check("rr_p0_ack", 32'(p0_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_p1_ack", 32'(p1_ack), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    check("rr_p0_data", p0_rdata, 32'hDEAD_BEEF);
    check("rr_p1_data", p1_rdata, 32'h0000_1234);
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Fixed priority: port 1 wins every tie
    f_p0_req = 1'b1; f_p1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_busy", 32'(f_busy), 32'd1);
      step();
      check("fp_p1_ack", 32'(f_p1_ack), 32'd1);
      check("fp_p0_ack", 32'(f_p0_ack), 32'd0);
    end
    check("fp_p1_data", f_p1_rdata, 32'hC0DE_0009);
    f_p0_req = 1'b0; f_p1_req = 1'b0;
    step();

    // Last valid word, then first invalid address
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd1023;
    step();
    step();
    check("edge_ack", 32'(p0_ack), 32'd1);
    check("edge_err", 32'(p0_err), 32'd0);
    check("edge_data", p0_rdata, 32'h5A5A_0001);
    wen_base = wen_count;
    p0_we = 1'b1; p0_addr = 32'd1024; p0_wdata = 32'h0000_FFFF;
    step();
    check("oor_busy", 32'(busy), 32'd1);
    check("oor_wen", 32'(mem_wen), 32'd0);
    step();
    check("oor_ack", 32'(p0_ack), 32'd1);
    check("oor_err", 32'(p0_err), 32'd1);
    check("oor_rdata", p0_rdata, 32'h0);
    check("oor_no_write", 32'(wen_count - wen_base), 32'd0);
    check("oor_mem0", mem[0], 32'h0);
    p0_req = 1'b0; p0_we = 1'b0;
    step();

    // Reset arriving during a write's BUSY cycle
    wen_base = wen_count;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd3; p1_wdata = 32'h0000_AAAA;
    step();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wen_gated", 32'(mem_wen), 32'd0);
    p1_req = 1'b0; p1_we = 1'b0;
    step();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(p1_ack), 32'd0);
    rst_n = 1'b1;
    step();
    check("mid_no_ack", 32'(p1_ack), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);
    check("mid_mem3", mem[3], 32'h0000_3333);
    check("mid_no_write", 32'(wen_count - wen_base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single-port-per-direction Memory block between the instruction-fetch requester (port 0) and the load/store requester (port 1). It serialises requests, drives the Memory raddr/waddr/wdata/wen inputs and returns read data or write completion with a one-cycle ack pulse. It also range-checks addresses so out-of-range accesses never reach the array. It sits between the core's fetch/LSU stages and Memory.

Parameters:
MEM_WORDS, 1024, number of addressable 32-bit words; any address >= MEM_WORDS is an error.
FIXED_PRIO, 0, 0 selects round-robin; 1 means port 1 always wins a tie.

Ports:
clk  input  1  system clock; all arbiter state updates on posedge.
rst_n  input  1  synchronous active-low reset.
p0_req  input  1  port 0 request; address and data are valid while high.
p0_we  input  1  port 0 write enable (1 = write, 0 = read).
p0_addr  input  32  port 0 word address.
p0_wdata  input  32  port 0 write data.
p0_ack  output  1  one-cycle completion pulse for port 0.
p0_err  output  1  valid with p0_ack; address was out of range.
p0_rdata  output  32  read data; valid with p0_ack.
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same definitions for port 1.
mem_raddr  output  32  to Memory raddr.
mem_waddr  output  32  to Memory waddr.
mem_wdata  output  32  to Memory wdata.
mem_wen  output  1  to Memory wen.
mem_rdata  input  32  from Memory rdata, which is updated on negedge clk.
busy  output  1  high while in BUSY state.

Behaviour:
- Reset (rst_n low at a posedge): state goes to IDLE. All ack, err and rdata outputs go to 0. cmd_addr, cmd_wdata and cmd_we go to 0. last_grant is set to 1, so port 0 wins the first tie.
- mem_wen = (state==BUSY) & cmd_we & ~cmd_err & rst_n. The rst_n term is combinational, so a write is suppressed in any cycle where reset is low.
- mem_raddr = mem_waddr = cmd_addr and mem_wdata = cmd_wdata at all times.
- FSM IDLE: at a posedge where any req is high, choose a winner, then:
  - latch that port's addr, wdata and we into cmd_*;
  - set cmd_err = (addr >= MEM_WORDS);
  - record cmd_port;
  - go to BUSY.
  If no req is high, stay in IDLE.
- Winner selection:
  - Only one req high: that port wins.
  - Both high with FIXED_PRIO=0: the port that is not last_grant wins.
  - Both high with FIXED_PRIO=1: port 1 wins.
  - last_grant updates on every grant.
- FSM BUSY lasts exactly one cycle. Memory performs the read or write on the negedge inside this cycle.
- At the posedge that ends BUSY:
  - pulse ack for cmd_port for the following cycle;
  - err = cmd_err;
  - rdata = mem_rdata for a good read, and 0 for writes or errors;
  - return to IDLE.
- Ack for the non-winning port stays 0. The p*_rdata outputs hold their value until the next ack on that port.
- Latency: req sampled at posedge T → BUSY during cycle T..T+1 → ack high during cycle T+1..T+2. Throughput is one access per 2 cycles.
- Handshake:
  - A requester holds req, addr, wdata and we stable until it sees ack.
  - A req still high during its ack cycle is treated as a new request and is sampled in IDLE at the end of that cycle.
  - A losing requester keeps req high and is served next.
- Requests are ignored while in BUSY. There is no queueing beyond the held req lines.
- Reset during BUSY: the pending access is aborted. There is no memory write in the reset cycle and no ack is issued.
- Address compare is a full 32-bit unsigned compare. There is no wrap.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE and ST_BUSY;
  - port index constants PORT_IF=0 and PORT_LS=1;
  - DATA_W=32 and ADDR_W=32.
- One sub-module, rr_arb2, covers the 2-way grant logic:
  - inputs req[1:0], last_grant and fixed_prio;
  - outputs grant_idx and grant_valid;
  - purely combinational.
- The FSM and the command/response registers stay in mem_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both req high → all ack=0, mem_wen=0, busy=0, and no grant until the first posedge after release.
- Single read: preload mem[5]=0xDEAD_BEEF; set p0_req=1 and p0_addr=5 at T → busy during T+1, p0_ack=1 with p0_rdata=0xDEAD_BEEF and p0_err=0 in cycle T+2, p1_ack stays 0.
- Write then read: p1 writes 0x1234 to address 7, then reads address 7 → first ack has rdata=0; mem_wen pulses exactly once, with waddr=7; second ack has rdata=0x1234.
- Contention with FIXED_PRIO=0: both ports request reads continuously → acks alternate p0, p1, p0, p1, with one ack every 2 cycles. With FIXED_PRIO=1 and both held → p1 only.
- Out of range: p0 writes 0xFFFF to address 1024 → p0_ack=1 and p0_err=1; mem_wen never asserts; mem[1024 mod anything] is unchanged.
- Reset mid-op: p1 writes 0xAAAA to address 3 and rst_n is driven low in its BUSY cycle → mem[3] is unchanged, no p1_ack, and state is IDLE after reset.
